// File: rtl/igen_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : igen_pipe_pkg
//  Brief   : Shared types and opcode constants for the immediate generator.
//  Revision: 1.0 - initial release
// ============================================================================
package igen_pipe_pkg;

  // Immediate format reported alongside each decoded beat
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  // RV base opcodes (insn[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_R_TYPE = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // Beat storage is sized for the widest legal configuration; narrower
  // instances keep only the low bits live.
  localparam int BEAT_AW = 64;
  localparam int BEAT_DW = 32;
  localparam int BEAT_XL = 64;

  typedef struct packed {
    logic [BEAT_AW-1:0] pc;
    logic [BEAT_DW-1:0] insn;
    logic [BEAT_XL-1:0] imm;
    imm_fmt_e           fmt;
    logic               illegal;
  } dec_beat_t;

endpackage
`default_nettype wire

// File: rtl/igen_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module  : igen_pipe_if
//  Brief   : Input/output handshake bundle of the immediate generator.
//  Revision: 1.0 - initial release
// ============================================================================
interface igen_pipe_if
  import igen_pipe_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int XLEN   = 32
) ();

  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [AWIDTH-1:0] pc_i;
  logic [DWIDTH-1:0] insn_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [AWIDTH-1:0] out_pc_o;
  logic [DWIDTH-1:0] out_insn_o;
  logic [XLEN-1:0]   imm_o;
  imm_fmt_e          imm_fmt_o;
  logic              illegal_o;

  // Upstream/downstream environment view
  modport master (
    output flush_i, in_valid_i, pc_i, insn_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_insn_o, imm_o, imm_fmt_o, illegal_o
  );

  // Generator view
  modport slave (
    input  flush_i, in_valid_i, pc_i, insn_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_insn_o, imm_o, imm_fmt_o, illegal_o
  );

endinterface
`default_nettype wire

// File: rtl/igen_pipe_core.sv
`default_nettype none
// ============================================================================
//  Module  : igen_core
//  Brief   : Combinational opcode classifier and immediate extractor.
//  Revision: 1.0 - initial release
// ============================================================================
module igen_core
  import igen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_insn,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_fmt,
  output logic            o_illegal
);

  // Decode opcode; signed casts sign-extend each raw field to XLEN
  always_comb begin
    o_imm     = '0;
    o_fmt     = FMT_NONE;
    o_illegal = 1'b0;
    unique case (i_insn[6:0])
      OPC_R_TYPE: ;
      OPC_IMM, OPC_LOAD, OPC_JALR, OPC_FENCE: begin
        o_fmt = FMT_I;
        o_imm = XLEN'($signed(i_insn[31:20]));
      end
      OPC_STORE: begin
        o_fmt = FMT_S;
        o_imm = XLEN'($signed({i_insn[31:25], i_insn[11:7]}));
      end
      OPC_BRANCH: begin
        o_fmt = FMT_B;
        o_imm = XLEN'($signed({i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0}));
      end
      OPC_JAL: begin
        o_fmt = FMT_J;
        o_imm = XLEN'($signed({i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        o_fmt = FMT_U;
        o_imm = XLEN'($signed({i_insn[31:12], 12'b0}));
      end
      OPC_SYSTEM: begin
        o_fmt = FMT_Z;
        o_imm = XLEN'(i_insn[19:15]);
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/igen_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : igen_pipe
//  Brief   : Registered immediate generator with 2-entry skid and flush.
//  Revision: 1.0 - initial release
// ============================================================================
module igen_pipe
  import igen_pipe_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int XLEN   = 32
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  igen_pipe_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $fatal(1, "igen_pipe: XLEN must be 32 or 64");
  end
  if (DWIDTH != BEAT_DW || AWIDTH > BEAT_AW || AWIDTH < 1) begin : g_bad_width
    $fatal(1, "igen_pipe: unsupported DWIDTH/AWIDTH");
  end

  logic [XLEN-1:0] w_imm;
  imm_fmt_e        w_fmt;
  logic            w_illegal;
  dec_beat_t       w_new;
  logic            w_adv;
  logic            w_accept;

  dec_beat_t r_out;
  dec_beat_t r_skid;
  logic      r_out_valid;
  logic      r_skid_valid;

  igen_core #(.XLEN(XLEN)) u_core (
    .i_insn    (bus.insn_i),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_illegal)
  );

  // Assemble the incoming beat with its decode result
  always_comb begin
    w_new         = '0;
    w_new.pc      = BEAT_AW'(bus.pc_i);
    w_new.insn    = bus.insn_i;
    w_new.imm     = BEAT_XL'(w_imm);
    w_new.fmt     = w_fmt;
    w_new.illegal = w_illegal;
  end

  // Output stage may advance when empty or being consumed; ready depends only on skid state
  assign w_adv    = !r_out_valid || bus.out_ready_i;
  assign w_accept = bus.in_valid_i && !r_skid_valid;

  // Valid bits: flush wins, skid drains before any new beat is taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (bus.flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_adv) begin
      r_out_valid  <= r_skid_valid || w_accept;
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
    end
  end

  // Output payload is reset so idle outputs read as zero / FMT_NONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out <= '0;
    end else if (!bus.flush_i && w_adv) begin
      if (r_skid_valid) begin
        r_out <= r_skid;
      end else if (w_accept) begin
        r_out <= w_new;
      end
    end
  end

  // Skid payload only captures while the output is stalled; valid bit guards it
  always_ff @(posedge clk_i) begin
    if (!bus.flush_i && !w_adv && w_accept) begin
      r_skid <= w_new;
    end
  end

  // Upper storage bits are dead in narrow configurations
  if (XLEN < BEAT_XL) begin : g_imm_pad
    logic w_unused_imm;
    assign w_unused_imm = ^r_out.imm[BEAT_XL-1:XLEN];
  end
  if (AWIDTH < BEAT_AW) begin : g_pc_pad
    logic w_unused_pc;
    assign w_unused_pc = ^r_out.pc[BEAT_AW-1:AWIDTH];
  end

  assign bus.in_ready_o  = !r_skid_valid;
  assign bus.out_valid_o = r_out_valid;
  assign bus.out_pc_o    = r_out.pc[AWIDTH-1:0];
  assign bus.out_insn_o  = r_out.insn;
  assign bus.imm_o       = r_out.imm[XLEN-1:0];
  assign bus.imm_fmt_o   = r_out.fmt;
  assign bus.illegal_o   = r_out.illegal;

  // A stalled upstream beat must keep its payload until taken
  a_in_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.in_valid_i && !bus.in_ready_o && !bus.flush_i) |=>
      (!bus.in_valid_i || ($stable(bus.pc_i) && $stable(bus.insn_i))))
    else $error("igen_pipe: input payload changed while stalled");

endmodule
`default_nettype wire
